// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_e   - arbiter FSM states (IDLE, BUSY_IF, BUSY_DM)
//   gnt_e     - grant selection (GNT_IF, GNT_DM)
//   NOP_INSTR - instruction returned to fetch when memory times out
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: chooses which requester wins the shared memory port.
// Config macro: MEM_ARB_RR_EN
//   undefined - fixed priority, DM wins a tie
//   defined   - round-robin on ties, last-grant pointer resets to IF
// Ports:
//   clk, rst  - clock / async active-high reset (round-robin build only)
//   take_i    - grant is being accepted this cycle (round-robin build only)
//   if_req_i  - fetch request (already masked by caller)
//   dm_req_i  - load/store request (already masked by caller)
//   gnt_o     - selected requester
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take_i,
`endif
  input  logic if_req_i,
  input  logic dm_req_i,
  output gnt_e gnt_o
);

`ifdef MEM_ARB_RR_EN
  gnt_e last_q;

  always_comb begin
    gnt_o = GNT_IF;
    if (if_req_i && dm_req_i) begin
      gnt_o = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
    end else if (dm_req_i) begin
      gnt_o = GNT_DM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_IF;
    end else if (take_i) begin
      last_q <= gnt_o;
    end
  end
`else
  always_comb begin
    gnt_o = dm_req_i ? GNT_DM : GNT_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction
// fetch port (IF) and a load/store port (DM).
// Config macro: MEM_ARB_RR_EN (round-robin tie break, see mem_arb_pick).
// Ports:
//   clk, rst                 - clock, async active-high reset
//   if_req/if_addr           - fetch request, held until if_valid
//   if_rdata/if_valid        - fetch data, 1-cycle completion pulse
//   dm_req/we/mask/addr/wdata- load/store request, held until dm_valid
//   dm_rdata/dm_valid        - load data, 1-cycle completion pulse
//   mem_req/we/mask/addr/wdata - registered memory request
//   mem_rdata/mem_ack        - memory read data and acknowledge
//   stall_if/stall_dm        - pipeline stalls
//   timeout_err              - sticky memory timeout flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_mask,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              timeout_err
);

  // Counter holds the number of busy cycles already elapsed, so the abort
  // fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic              err_q, err_d;

  // A requester is invisible during its own completion pulse, since it
  // still holds req in that cycle.
  logic if_req_m, dm_req_m;
  gnt_e gnt;

  assign if_req_m = if_req & ~if_valid_q;
  assign dm_req_m = dm_req & ~dm_valid_q;

`ifdef MEM_ARB_RR_EN
  logic take;
  assign take = (state_q == IDLE) && (if_req_m || dm_req_m);

  mem_arb_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .take_i   (take),
    .if_req_i (if_req_m),
    .dm_req_i (dm_req_m),
    .gnt_o    (gnt)
  );
`else
  mem_arb_pick u_pick (
    .if_req_i (if_req_m),
    .dm_req_i (dm_req_m),
    .gnt_o    (gnt)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_mask_d  = mem_mask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (if_req_m || dm_req_m) begin
          mem_req_d = 1'b1;
          cnt_d     = '0;
          if (gnt == GNT_DM) begin
            state_d     = BUSY_DM;
            mem_we_d    = dm_we;
            mem_mask_d  = dm_mask;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            state_d     = BUSY_IF;
            mem_we_d    = 1'b0;
            mem_mask_d  = '0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        // Ack on the final counted cycle still wins over the abort.
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          err_d     = 1'b1;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = DATA_W'(NOP_INSTR);
          end else begin
            dm_valid_d = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_mask_q  <= mem_mask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      err_q       <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_mask    = mem_mask_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_valid    = if_valid_q;
  assign dm_valid    = dm_valid_q;
  assign timeout_err = err_q;
  assign stall_if    = if_req & ~if_valid_q;
  assign stall_dm    = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req, dm_we;
  logic [3:0]  dm_mask;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_valid;
  logic        mem_req, mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall_if, stall_dm, timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_mask     (dm_mask),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_valid    (dm_valid),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_mask    (mem_mask),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stall_if    (stall_if),
    .stall_dm    (stall_dm),
    .timeout_err (timeout_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_mask = '0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    tick; tick;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b%b exp=00", if_valid, dm_valid); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", timeout_err); end
    checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_mask !== 4'h0) begin failures++; $display("FAIL rst_mem got=%h/%b/%h exp=0", mem_addr, mem_we, mem_mask); end
    rst = 1'b0;
    tick;
  endtask

  // Ack arrives on the 4th busy cycle, the same edge the counter would
  // reach TIMEOUT_CYCLES=4, so this is also the ack-wins boundary.
  task automatic test_fetch;
    if_req = 1; if_addr = 32'h100;
    #1;
    checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL fetch_stall0 got=%b exp=1", stall_if); end
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_req got=%b/%h exp=1/100", mem_req, mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_mask !== 4'h0) begin failures++; $display("FAIL fetch_we_mask got=%b/%h exp=0/0", mem_we, mem_mask); end
    tick; tick; tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_hold got=%b/%h exp=1/100", mem_req, mem_addr); end
    checks++; if (stall_if !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL fetch_stall1 got=%b/%b exp=1/0", stall_if, if_valid); end
    mem_ack = 1; mem_rdata = 32'h00500093;
    tick;
    mem_ack = 0;
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL fetch_valid got=%b exp=1", if_valid); end
    checks++; if (if_rdata !== 32'h00500093) begin failures++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
    checks++; if (mem_req !== 1'b0 || stall_if !== 1'b0) begin failures++; $display("FAIL fetch_done got=%b/%b exp=0/0", mem_req, stall_if); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL fetch_boundary_err got=%b exp=0", timeout_err); end
    // if_req still held through the valid cycle: must be masked
    tick;
    checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL fetch_mask got=%b/%b exp=0/0", mem_req, if_valid); end
    checks++; if (if_rdata !== 32'h00500093) begin failures++; $display("FAIL fetch_rdata_hold got=%h exp=00500093", if_rdata); end
    if_req = 0;
    tick;
  endtask

  task automatic test_both;
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 1; dm_mask = 4'b0011; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (stall_dm !== 1'b1) begin failures++; $display("FAIL both_stall_dm got=%b exp=1", stall_dm); end
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin failures++; $display("FAIL both_dm_first got=%b/%h exp=1/2000", mem_req, mem_addr); end
    checks++; if (mem_we !== 1'b1 || mem_mask !== 4'b0011 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL both_dm_fields got=%b/%h/%h exp=1/3/deadbeef", mem_we, mem_mask, mem_wdata); end
    mem_ack = 1; mem_rdata = 32'h12345678;
    tick;
    checks++; if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL both_dm_valid got=%b/%b exp=1/0", dm_valid, if_valid); end
    checks++; if (dm_rdata !== 32'h0) begin failures++; $display("FAIL both_wr_rdata got=%h exp=0", dm_rdata); end
    mem_ack = 0; dm_req = 0;
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin failures++; $display("FAIL both_if_second got=%b/%h exp=1/200", mem_req, mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_mask !== 4'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL both_if_fields got=%b/%h/%h exp=0/0/0", mem_we, mem_mask, mem_wdata); end
    mem_ack = 1; mem_rdata = 32'hAABBCCDD;
    tick;
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hAABBCCDD) begin failures++; $display("FAIL both_if_valid got=%b/%h exp=1/aabbccdd", if_valid, if_rdata); end
    mem_ack = 0; if_req = 0;
    tick;
  endtask

  // Both held: each side is masked during its own valid pulse, so the
  // other side is taken next -> DM, IF, DM, IF in either build.
  task automatic test_back_to_back;
    logic [31:0] exp_addr;
    logic [31:0] rd;
    dm_we = 0; dm_mask = 4'hF; dm_addr = 32'h3000; if_addr = 32'h400;
    if_req = 1; dm_req = 1;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h3000 : 32'h400;
      rd = 32'hA000_0000 + k;
      tick;
      checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin failures++; $display("FAIL b2b_grant%0d got=%b/%h exp=1/%h", k, mem_req, mem_addr, exp_addr); end
      mem_ack = 1; mem_rdata = rd;
      tick;
      mem_ack = 0;
      if (k % 2 == 0) begin
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== rd) begin failures++; $display("FAIL b2b_dm%0d got=%b/%h exp=1/%h", k, dm_valid, dm_rdata, rd); end
      end else begin
        checks++; if (if_valid !== 1'b1 || if_rdata !== rd) begin failures++; $display("FAIL b2b_if%0d got=%b/%h exp=1/%h", k, if_valid, if_rdata, rd); end
      end
    end
    if_req = 0; dm_req = 0;
    tick;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", mem_req); end
  endtask

  // Two fresh ties from IDLE: fixed priority gives DM both times,
  // round-robin gives DM then IF.
  task automatic test_tie_priority;
    logic [31:0] exp_addr;
    if_addr = 32'h400;
    dm_we = 1; dm_mask = 4'hF; dm_addr = 32'h2004; dm_wdata = 32'h11;
    if_req = 1; dm_req = 1;
    tick;
    checks++; if (mem_addr !== 32'h2004 || mem_we !== 1'b1) begin failures++; $display("FAIL tie1_grant got=%h/%b exp=2004/1", mem_addr, mem_we); end
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    tick;
    mem_ack = 0; if_req = 0; dm_req = 0;
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hA0000002) begin failures++; $display("FAIL tie1_wr_keep got=%b/%h exp=1/a0000002", dm_valid, dm_rdata); end
    tick;
    if_req = 1; dm_req = 1;
`ifdef MEM_ARB_RR_EN
    exp_addr = 32'h400;
`else
    exp_addr = 32'h2004;
`endif
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin failures++; $display("FAIL tie2_grant got=%b/%h exp=1/%h", mem_req, mem_addr, exp_addr); end
    mem_ack = 1; mem_rdata = 32'hB0;
    tick;
    mem_ack = 0; if_req = 0; dm_req = 0;
`ifdef MEM_ARB_RR_EN
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hB0) begin failures++; $display("FAIL tie2_valid got=%b/%h exp=1/b0", if_valid, if_rdata); end
`else
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hA0000002) begin failures++; $display("FAIL tie2_valid got=%b/%h exp=1/a0000002", dm_valid, dm_rdata); end
`endif
    tick;
  endtask

  task automatic test_ack_idle;
    mem_ack = 1; mem_rdata = 32'h55;
    tick;
    mem_ack = 0;
    checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || dm_valid !== 1'b0) begin failures++; $display("FAIL ack_idle got=%b/%b/%b exp=0/0/0", mem_req, if_valid, dm_valid); end
    tick;
  endtask

  task automatic test_timeout;
    if_req = 1; if_addr = 32'h500;
    tick;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL to_req got=%b exp=1", mem_req); end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (mem_req !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL to_busy%0d got=%b/%b exp=1/0", i, mem_req, if_valid); end
    end
    tick;
    checks++; if (mem_req !== 1'b0 || if_valid !== 1'b1) begin failures++; $display("FAIL to_abort got=%b/%b exp=0/1", mem_req, if_valid); end
    checks++; if (if_rdata !== 32'h00000013) begin failures++; $display("FAIL to_nop got=%h exp=00000013", if_rdata); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    if_req = 0;
    tick;
    checks++; if (if_valid !== 1'b0 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_after got=%b/%b exp=0/1", if_valid, timeout_err); end
    dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
    tick;
    mem_ack = 1; mem_rdata = 32'hC;
    tick;
    mem_ack = 0; dm_req = 0;
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hC || timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b/%h/%b exp=1/c/1", dm_valid, dm_rdata, timeout_err); end
    tick;
  endtask

  task automatic test_reset_mid;
    dm_req = 1; dm_we = 0; dm_addr = 32'h3008;
    tick;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3008) begin failures++; $display("FAIL rm_busy got=%b/%h exp=1/3008", mem_req, mem_addr); end
    tick;
    mem_ack = 1; mem_rdata = 32'h77;
    rst = 1;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || dm_valid !== 1'b0) begin failures++; $display("FAIL rm_async got=%b/%h/%b exp=0/0/0", mem_req, mem_addr, dm_valid); end
    checks++; if (timeout_err !== 1'b0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL rm_clear got=%b/%h/%h exp=0/0/0", timeout_err, if_rdata, dm_rdata); end
    dm_req = 0;
    tick;
    rst = 0;
    tick;
    checks++; if (dm_valid !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL rm_late_ack got=%b/%b/%h exp=0/0/0", dm_valid, mem_req, dm_rdata); end
    mem_ack = 0;
    tick;
    checks++; if (dm_valid !== 1'b0) begin failures++; $display("FAIL rm_no_valid got=%b exp=0", dm_valid); end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_both;
    test_back_to_back;
    test_tie_priority;
    test_ack_idle;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
